// File: rtl/l2_pool_pkg.sv
// l2_pool_pkg: shared constants and state type for the l2_pool pooling/flatten stage.
package l2_pool_pkg;
  localparam int N_POS  = 25;
  localparam int N_CH   = 4;
  localparam int N_WIN  = 4;
  localparam int N_FLAT = 100;
  localparam int ADDR_W = 7;

  typedef enum logic {FILL, DRAIN} l2_pool_state_t;
endpackage

// File: rtl/ram.sv
// ram: simple dual-port synchronous RAM, one write port and one read port with 1-cycle latency.
module ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  i_wrEn,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_rdEn,
  input  logic [ADDR_WIDTH-1:0] i_rdAddr,
  output logic [DATA_WIDTH-1:0] o_rdData
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
  end
endmodule

// File: rtl/l2_pool.sv
// l2_pool: 2x2 max pooling (average pooling when L2_POOL_AVG_EN is defined) of conv-2 samples,
// stored channel-major and drained as 100 flattened words over valid/ready.
module l2_pool #(
  parameter int DATA_W = 18,
  parameter int N_POS  = 25,
  parameter int N_CH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_done,
  input  logic              din_vld,
  input  logic [DATA_W-1:0] din,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic [DATA_W-1:0] dout,
  output logic              bsy,
  output logic              ovf
);
  import l2_pool_pkg::*;

`ifdef L2_POOL_AVG_EN
  localparam int ACC_W = DATA_W + 2;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int POS_W = $clog2(N_POS);
  localparam int CH_W  = $clog2(N_CH);
  localparam int WIN_W = $clog2(N_WIN);

  l2_pool_state_t    r_state, w_stateNext;
  logic [WIN_W-1:0]  r_win;
  logic [CH_W-1:0]   r_ch;
  logic [POS_W-1:0]  r_pos;
  logic [ACC_W-1:0]  r_acc, w_accIn, w_dinExt;
  logic [DATA_W-1:0] w_result;
  logic              w_clear, w_take, w_winLast, w_chLast, w_posLast;
  logic [ADDR_W-1:0] w_wrAddr;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;
  logic              r_ovf;

  logic [ADDR_W-1:0] r_rdAddr, r_xferCnt;
  logic              r_rdPend, r_head;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_buf [2];
  logic [DATA_W-1:0] w_rdData;
  logic [2:0]        w_inFlight;
  logic              w_pop, w_issue, w_xferLast;

  assign w_clear   = rst | tx_done;
  assign w_take    = din_vld && (r_state == FILL);
  assign w_winLast = (r_win == WIN_W'(N_WIN - 1));
  assign w_chLast  = (r_ch == CH_W'(N_CH - 1));
  assign w_posLast = (r_pos == POS_W'(N_POS - 1));
  assign w_wrAddr  = ADDR_W'(int'(r_ch) * N_POS + int'(r_pos));
  assign w_dinExt  = ACC_W'(din);

`ifdef L2_POOL_AVG_EN
  assign w_accIn  = r_acc + w_dinExt;
  assign w_result = w_accIn[ACC_W-1:2];
`else
  assign w_accIn  = (w_dinExt > r_acc) ? w_dinExt : r_acc;
  assign w_result = w_accIn;
`endif

  always_ff @(posedge clk) begin
    if (w_clear) r_state <= FILL;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      FILL:    if (w_take && w_winLast && w_chLast && w_posLast) w_stateNext = DRAIN;
      DRAIN:   if (w_pop && w_xferLast) w_stateNext = FILL;
      default: w_stateNext = FILL;
    endcase
  end

  // Window/channel/position counters; pos only returns to 0 as the frame completes.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_win <= '0;
      r_ch  <= '0;
      r_pos <= '0;
      r_acc <= '0;
    end else if (w_take) begin
      r_acc <= (r_win == '0) ? w_dinExt : w_accIn;
      if (w_winLast) begin
        r_win <= '0;
        if (w_chLast) begin
          r_ch  <= '0;
          r_pos <= w_posLast ? '0 : r_pos + 1'b1;
        end else begin
          r_ch <= r_ch + 1'b1;
        end
      end else begin
        r_win <= r_win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      r_wrEn <= w_take && w_winLast;
      if (w_take && w_winLast) begin
        r_wrAddr <= w_wrAddr;
        r_wrData <= w_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear)                           r_ovf <= 1'b0;
    else if (din_vld && r_state == DRAIN)  r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
  assign bsy = (r_state == DRAIN);

  // Read side: a read is issued only if its data is guaranteed a free buffer slot on arrival.
  assign dout_vld   = (r_cnt != 2'd0);
  assign dout       = r_buf[r_head];
  assign w_pop      = dout_vld && dout_rdy;
  assign w_xferLast = (r_xferCnt == ADDR_W'(N_FLAT - 1));
  assign w_inFlight = 3'(r_cnt) + 3'(r_rdPend);
  assign w_issue    = (r_state == DRAIN) && (r_rdAddr < ADDR_W'(N_FLAT)) &&
                      (w_inFlight <= 3'd1 + 3'(w_pop));

  always_ff @(posedge clk) begin
    if (w_clear || (w_pop && w_xferLast)) begin
      r_rdAddr  <= '0;
      r_xferCnt <= '0;
      r_rdPend  <= 1'b0;
      r_cnt     <= 2'd0;
      r_head    <= 1'b0;
      if (w_clear) begin
        r_buf[0] <= '0;
        r_buf[1] <= '0;
      end
    end else begin
      r_rdPend <= w_issue;
      if (w_issue) r_rdAddr <= r_rdAddr + 1'b1;
      if (r_rdPend) r_buf[r_head ^ r_cnt[0]] <= w_rdData;
      if (w_pop) begin
        r_head    <= ~r_head;
        r_xferCnt <= r_xferCnt + 1'b1;
      end
      r_cnt <= r_cnt + 2'(r_rdPend) - 2'(w_pop);
    end
  end

  ram #(
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (r_wrEn),
    .i_wrAddr (r_wrAddr),
    .i_wrData (r_wrData),
    .i_rdEn   (w_issue),
    .i_rdAddr (r_rdAddr),
    .o_rdData (w_rdData)
  );
endmodule

// File: tb/tb_l2_pool.sv
// tb_l2_pool: directed frames for l2_pool checked against a window-level pooling model
// (max by default, average when L2_POOL_AVG_EN is defined).
`timescale 1ns/1ps
module tb_l2_pool;
  logic        clk = 1'b0;
  logic        rst, tx_done, din_vld;
  logic [17:0] din;
  logic        dout_vld, bsy, ovf;
  logic        dout_rdy = 1'b1;
  logic [17:0] dout;

  int nErrors = 0;
  int nChecks = 0;
  int expFrame [100];
  int expQ [$];
  int frameXfers = 0;
  int xferBase = 0;
  int firstXferCyc = 0;
  int lastXferCyc = 0;
  int cyc = 0;
  bit bpMode = 1'b0;
  int bpPhase = 0;

  always #5 clk = ~clk;

  l2_pool dut (
    .clk      (clk),
    .rst      (rst),
    .tx_done  (tx_done),
    .din_vld  (din_vld),
    .din      (din),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout     (dout),
    .bsy      (bsy),
    .ovf      (ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int sampleVal(input int f, input int p, input int c, input int w);
    int base [4];
    if (f == 2 && p == 0 && c == 0) begin
      base = '{32'h20000, 32'h1FFFF, 0, 1};
      return base[w];
    end
    if (f == 3 && p == 1 && c == 0) begin
      base = '{4, 5, 6, 7};
      return base[w];
    end
    if (f == 3 && p == 1 && c == 1) begin
      base = '{3, 3, 3, 2};
      return base[w];
    end
    case (f)
      1:       begin base = '{1, 5, 3, 2}; return base[w] + 10 * c + 100 * p;  end
      2:       begin base = '{7, 1, 4, 6}; return base[w] + 7 * c + 1000 * p;  end
      default: begin base = '{9, 2, 8, 3}; return base[w] + 20 * c + 300 * p;  end
    endcase
  endfunction

  function automatic int reduceWin(input int s0, input int s1, input int s2, input int s3);
    int m;
`ifdef L2_POOL_AVG_EN
    m = (s0 + s1 + s2 + s3) / 4;
`else
    m = s0;
    if (s1 > m) m = s1;
    if (s2 > m) m = s2;
    if (s3 > m) m = s3;
`endif
    return m;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bpMode) begin
      dout_rdy = ((bpPhase % 4) == 0) || ((bpPhase % 4) == 3);
      bpPhase++;
    end else begin
      dout_rdy = 1'b1;
    end
  end

  // Every cycle a word is offered it must equal the oldest outstanding model word.
  always @(negedge clk) begin
    if (dout_vld === 1'b1) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpectedWord: got 0x%0h, expected no word", dout);
      end else begin
        checkOutput($sformatf("word%0d", frameXfers - xferBase), dout, expQ[0]);
        if (dout_rdy) begin
          checkOutput("bsyDuringXfer", bsy, 1);
          if (frameXfers == xferBase) firstXferCyc = cyc;
          lastXferCyc = cyc;
          void'(expQ.pop_front());
          frameXfers++;
        end
      end
    end
  end

  task automatic sendSample(input int v);
    din     = 18'(v);
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    din     = '0;
  endtask

  task automatic applyStimulus(input int f);
    int v [4];
    xferBase = frameXfers;
    for (int p = 0; p < 25; p++) begin
      for (int c = 0; c < 4; c++) begin
        for (int w = 0; w < 4; w++) begin
          v[w] = sampleVal(f, p, c, w);
          sendSample(v[w]);
        end
        expFrame[c * 25 + p] = reduceWin(v[0], v[1], v[2], v[3]);
      end
    end
    for (int k = 0; k < 100; k++) expQ.push_back(expFrame[k]);
  endtask

  task automatic waitDrain(input string tag, input bit checkRate);
    int budget = 1000;
    while ((frameXfers - xferBase) < 100 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if ((frameXfers - xferBase) < 100) begin
      checkOutput({tag, "_drainTimeout"}, frameXfers - xferBase, 100);
    end else begin
      checkOutput({tag, "_bsyLastXfer"}, bsy, 1);
      @(negedge clk);
      #1;
      checkOutput({tag, "_bsyAfter"}, bsy, 0);
      checkOutput({tag, "_vldAfter"}, dout_vld, 0);
      if (checkRate) checkOutput({tag, "_rate"}, lastXferCyc - firstXferCyc, 99);
    end
    checkOutput({tag, "_leftover"}, expQ.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tx_done = 1'b0; din_vld = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstVld", dout_vld, 0);
    checkOutput("rstDout", dout, 0);
    checkOutput("rstBsy", bsy, 0);
    checkOutput("rstOvf", ovf, 0);

    $display("[TB] frame 1: clean frame, dout_rdy held high");
    applyStimulus(1);
`ifdef L2_POOL_AVG_EN
    checkOutput("pinF1k0", expFrame[0], 2);
    checkOutput("pinF1k26", expFrame[26], 112);
    checkOutput("pinF1k99", expFrame[99], 2432);
`else
    checkOutput("pinF1k0", expFrame[0], 5);
    checkOutput("pinF1k26", expFrame[26], 115);
    checkOutput("pinF1k99", expFrame[99], 2435);
`endif
    @(negedge clk); #1;
    checkOutput("drain0Bsy", bsy, 1);
    checkOutput("drain0Vld", dout_vld, 0);
    @(negedge clk); #1;
    checkOutput("drain1Vld", dout_vld, 0);
    @(negedge clk); #1;
    checkOutput("drain2Vld", dout_vld, 1);
    waitDrain("f1", 1'b1);

    $display("[TB] frame 2: backpressure, unsigned top bit, overflow");
    bpPhase = 0;
    bpMode  = 1'b1;
    applyStimulus(2);
`ifdef L2_POOL_AVG_EN
    checkOutput("pinF2k0", expFrame[0], 32'h10000);
`else
    checkOutput("pinF2k0", expFrame[0], 32'h20000);
`endif
    din     = 18'h3FFFF;
    din_vld = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    din_vld = 1'b0;
    din     = '0;
    @(negedge clk); #1;
    checkOutput("ovfSet", ovf, 1);
    waitDrain("f2", 1'b0);
    checkOutput("ovfSticky", ovf, 1);
    bpMode = 1'b0;

    $display("[TB] frame 3: clear, mid-window abort, then clean frame");
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk); #1;
    checkOutput("ovfCleared", ovf, 0);
    checkOutput("bsyIdle", bsy, 0);
    sendSample(32'h3FFFF);
    sendSample(32'h3FFFE);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    applyStimulus(3);
`ifdef L2_POOL_AVG_EN
    checkOutput("pinF3k0", expFrame[0], 5);
    checkOutput("pinF3k1", expFrame[1], 5);
    checkOutput("pinF3k26", expFrame[26], 2);
`else
    checkOutput("pinF3k0", expFrame[0], 9);
    checkOutput("pinF3k1", expFrame[1], 7);
    checkOutput("pinF3k26", expFrame[26], 3);
`endif
    waitDrain("f3", 1'b1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
